// File: rtl/tile_rmw_ctrl.sv
// Per-frame tile read-modify-write sequencer: pixel->tile address, map RAM read, update-stage writeback, BCD score, dot count.
// Optional build macro TICK_OVERRUN_EN: sticky flag for a tick that arrives while a sequence is in flight.
module tile_rmw_ctrl #(
  parameter int TILE_W         = 40,
  parameter int TILE_H         = 40,
  parameter int MAP_COLS       = 16,
  parameter int MAP_ROWS       = 12,
  parameter int ADDR_W         = 8,
  parameter int X_ORIGIN       = 0,
  parameter int Y_ORIGIN       = 0,
  parameter int DOT_TOTAL      = 150,
  parameter int DOT_EATEN_CODE = 34
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [9:0]        xpos,
  input  logic [8:0]        ypos,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] map_addr,
  input  logic [5:0]        map_rdata,
  output logic [5:0]        map_wdata,
  output logic              map_we,
  output logic [5:0]        blk_in,
  output logic [9:0]        rel_xpos,
  output logic [8:0]        rel_ypos,
  input  logic [5:0]        blk_out,
  input  logic              blk_we,
  input  logic              blk_point,
  output logic [15:0]       score_bcd,
  output logic              score_ovf,
  output logic [7:0]        dots_left,
  output logic              level_clear,
  output logic              tick_overrun
);
  typedef enum logic [2:0] {S_IDLE, S_DIV, S_READ, S_EVAL, S_APPLY, S_SKIP} state_t;

  localparam logic [9:0] LP_TW    = 10'(TILE_W);
  localparam logic [8:0] LP_TH    = 9'(TILE_H);
  localparam logic [7:0] LP_COLS  = 8'(MAP_COLS);
  localparam logic [7:0] LP_ROWS  = 8'(MAP_ROWS);
  localparam logic [7:0] LP_DOTS  = 8'(DOT_TOTAL);
  localparam logic [5:0] LP_EATEN = 6'(DOT_EATEN_CODE);

  state_t            r_state, w_next;
  logic [9:0]        r_rem_x;
  logic [8:0]        r_rem_y;
  logic [7:0]        r_col, r_row;
  logic [ADDR_W-1:0] r_map_addr;
  logic [5:0]        r_blk_in;
  logic [9:0]        r_rel_x;
  logic [8:0]        r_rel_y;
  logic [15:0]       r_score;
  logic              r_ovf;
  logic [7:0]        r_dots;

  // Extra MSB on the origin subtraction doubles as the "left of / above playfield" flag.
  logic [10:0] w_dx;
  logic [9:0]  w_dy;
  logic        w_off, w_x_ge, w_y_ge, w_oob, w_apply, w_point, w_eat;
  logic [15:0] w_lin;
  logic [15:0] w_score_inc;
  logic        w_wrap;

  assign w_dx    = {1'b0, xpos} - 11'(X_ORIGIN);
  assign w_dy    = {1'b0, ypos} - 10'(Y_ORIGIN);
  assign w_off   = w_dx[10] | w_dy[9];
  assign w_x_ge  = (r_rem_x >= LP_TW);
  assign w_y_ge  = (r_rem_y >= LP_TH);
  assign w_oob   = (r_col == LP_COLS) | (r_row == LP_ROWS);
  assign w_lin   = 16'(r_row) * 16'(MAP_COLS) + 16'(r_col);
  assign w_apply = (r_state == S_APPLY) & ~rst;
  assign w_point = w_apply & blk_point;
  assign w_eat   = w_point & (blk_out == LP_EATEN) & (r_dots != 8'd0);

  always_comb begin
    w_wrap      = 1'b1;
    w_score_inc = r_score;
    for (int i = 0; i < 4; i++) begin
      if (w_wrap) begin
        if (r_score[4*i +: 4] == 4'd9) begin
          w_score_inc[4*i +: 4] = 4'd0;
        end else begin
          w_score_inc[4*i +: 4] = r_score[4*i +: 4] + 4'd1;
          w_wrap                = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    busy      = (r_state != S_IDLE);
    done      = 1'b0;
    map_we    = 1'b0;
    map_wdata = 6'd0;
    case (r_state)
      S_IDLE:  if (tick) w_next = w_off ? S_SKIP : S_DIV;
      S_DIV: begin
        if (w_oob)                    w_next = S_SKIP;
        else if (!w_x_ge && !w_y_ge)  w_next = S_READ;
      end
      S_READ:  w_next = S_EVAL;
      S_EVAL:  w_next = S_APPLY;
      S_APPLY: begin
        done      = ~rst;
        map_we    = blk_we & ~rst;
        map_wdata = rst ? 6'd0 : blk_out;
        w_next    = S_IDLE;
      end
      S_SKIP: begin
        done   = ~rst;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem_x    <= '0;
      r_rem_y    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_map_addr <= '0;
      r_blk_in   <= '0;
      r_rel_x    <= '0;
      r_rel_y    <= '0;
      r_score    <= '0;
      r_ovf      <= 1'b0;
      r_dots     <= LP_DOTS;
    end else begin
      case (r_state)
        S_IDLE: if (tick) begin
          r_rel_x <= w_dx[9:0];
          r_rel_y <= w_dy[8:0];
          r_rem_x <= w_dx[9:0];
          r_rem_y <= w_dy[8:0];
          r_col   <= '0;
          r_row   <= '0;
        end
        S_DIV: begin
          // Repeated subtraction: one tile step per axis per cycle.
          if (w_x_ge) begin
            r_rem_x <= r_rem_x - LP_TW;
            r_col   <= r_col + 8'd1;
          end
          if (w_y_ge) begin
            r_rem_y <= r_rem_y - LP_TH;
            r_row   <= r_row + 8'd1;
          end
          if (!w_oob && !w_x_ge && !w_y_ge) r_map_addr <= ADDR_W'(w_lin);
        end
        S_EVAL:  r_blk_in <= map_rdata;
        default: ;
      endcase
      if (w_point) begin
        r_score <= w_score_inc;
        if (w_wrap) r_ovf <= 1'b1;
      end
      if (w_eat) r_dots <= r_dots - 8'd1;
    end
  end

  assign map_addr    = r_map_addr;
  assign blk_in      = r_blk_in;
  assign rel_xpos    = r_rel_x;
  assign rel_ypos    = r_rel_y;
  assign score_bcd   = r_score;
  assign score_ovf   = r_ovf;
  assign dots_left   = r_dots;
  assign level_clear = w_eat & (r_dots == 8'd1);

`ifdef TICK_OVERRUN_EN
  logic r_tick_ovr;
  always_ff @(posedge clk) begin
    if (rst)                          r_tick_ovr <= 1'b0;
    else if (tick && busy)            r_tick_ovr <= 1'b1;
  end
  assign tick_overrun = r_tick_ovr;
`else
  assign tick_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_tile_rmw_ctrl.sv
// Scoreboard bench for tile_rmw_ctrl: behavioural map RAM, stubbed update stage, queue of expected sequence results.
`timescale 1ns/1ps
module tb_tile_rmw_ctrl;
  localparam int TW = 40;
  localparam int TH = 40;
`ifdef TICK_OVERRUN_EN
  localparam bit EXP_OVR = 1'b1;
`else
  localparam bit EXP_OVR = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, tick = 1'b0;
  logic [9:0] xpos = '0;
  logic [8:0] ypos = '0;
  logic busy, done, map_we, level_clear, tick_overrun, score_ovf;
  logic [7:0] map_addr, dots_left;
  logic [5:0] map_rdata, map_wdata, blk_in;
  logic [9:0] rel_xpos;
  logic [8:0] rel_ypos;
  logic [5:0] blk_out = '0;
  logic blk_we = 1'b0, blk_point = 1'b0;
  logic [15:0] score_bcd;

  tile_rmw_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .xpos(xpos), .ypos(ypos),
    .busy(busy), .done(done), .map_addr(map_addr), .map_rdata(map_rdata),
    .map_wdata(map_wdata), .map_we(map_we), .blk_in(blk_in),
    .rel_xpos(rel_xpos), .rel_ypos(rel_ypos), .blk_out(blk_out),
    .blk_we(blk_we), .blk_point(blk_point), .score_bcd(score_bcd),
    .score_ovf(score_ovf), .dots_left(dots_left), .level_clear(level_clear),
    .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0] mem [0:255];
  logic [5:0] sh  [0:255];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = '0;
  logic [5:0] ld_dat = '0;
  always @(posedge clk) begin
    if (ld_en)       mem[ld_addr]  <= ld_dat;
    else if (map_we) mem[map_addr] <= map_wdata;
    map_rdata <= mem[map_addr];
  end

  int we_cnt = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (map_we) we_cnt <= we_cnt + 1;
    if (done)   done_cnt <= done_cnt + 1;
  end

  typedef struct {
    bit skip; int lat; logic [7:0] addr; logic [5:0] wdat; bit we;
    logic [5:0] blkin; bit lc; logic [15:0] score; logic [7:0] dots; bit ovf;
  } exp_t;
  exp_t sbq[$];

  int m_score = 0, m_dots = 150;
  bit m_ovf = 1'b0;
  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic bit model_point(input logic [5:0] bo);
    bit lc = 1'b0;
    m_score++;
    if (m_score == 10000) begin m_score = 0; m_ovf = 1'b1; end
    if (bo == 6'd34 && m_dots != 0) begin lc = (m_dots == 1); m_dots--; end
    return lc;
  endfunction

  task automatic ram_load(input int a, input logic [5:0] d);
    @(negedge clk); ld_en = 1'b1; ld_addr = 8'(a); ld_dat = d; sh[a] = d;
    @(negedge clk); ld_en = 1'b0;
  endtask

  task automatic run_seq(input int x, input int y, input logic [5:0] bo,
                         input logic bwe, input logic bpt, input bit hold);
    exp_t e;
    int col, row, t0;
    bit seen;
    e = '{default: 0};
    col = x / TW; row = y / TH;
    e.skip = (col >= 16) || (row >= 12);
    if (e.skip) begin
      e.lat = 999;
      if (col >= 16) e.lat = 18;
      if (row >= 12 && e.lat > 14) e.lat = 14;
    end else begin
      e.lat = ((col > row) ? col : row) + 4;
      e.addr = 8'(row * 16 + col);
      e.blkin = sh[e.addr];
      e.we = bwe; e.wdat = bo;
      if (bpt) e.lc = model_point(bo);
      if (bwe) sh[e.addr] = bo;
    end
    e.score = to_bcd(m_score); e.dots = 8'(m_dots); e.ovf = m_ovf;
    sbq.push_back(e);

    @(negedge clk);
    xpos = 10'(x); ypos = 9'(y); blk_out = bo; blk_we = bwe; blk_point = bpt;
    tick = 1'b1; t0 = cyc;
    @(negedge clk);
    if (!hold) tick = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    tick = 1'b0;
    e = sbq.pop_front();
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    chk("latency", cyc - t0, e.lat);
    chk("map_we", map_we, e.we);
    chk("level_clear", level_clear, e.lc);
    if (!e.skip) begin
      chk("map_addr", map_addr, e.addr);
      chk("blk_in", blk_in, e.blkin);
      if (e.we) chk("map_wdata", map_wdata, e.wdat);
    end
    @(negedge clk);
    chk("done_single", done, 1'b0);
    chk("we_single", map_we, 1'b0);
    chk("busy_after", busy, 1'b0);
    chk("score", score_bcd, e.score);
    chk("dots", dots_left, e.dots);
    chk("ovf", score_ovf, e.ovf);
  endtask

  task automatic bulk(input int n, input logic [5:0] bo, input logic bpt);
    int got = 0;
    int budget = n * 6 + 20;
    @(negedge clk);
    xpos = '0; ypos = '0; blk_out = bo; blk_we = 1'b1; blk_point = bpt; tick = 1'b1;
    while (got < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (done) begin
        got++;
        if (got == n) tick = 1'b0;
      end
    end
    tick = 1'b0;
    chk("bulk_count", got, n);
    for (int i = 0; i < got; i++) if (bpt) void'(model_point(bo));
    sh[0] = bo;
    @(negedge clk);
  endtask

  initial begin
    int w0, d0;
    for (int a = 0; a < 256; a++) ram_load(a, 6'd0);
    ram_load(50, 6'd3);
    ram_load(9, 6'd21);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_we", map_we, 1'b0);
    chk("rst_addr", map_addr, 8'd0);
    chk("rst_wdata", map_wdata, 6'd0);
    chk("rst_blk_in", blk_in, 6'd0);
    chk("rst_rel", {rel_xpos, rel_ypos}, 19'd0);
    chk("rst_score", score_bcd, 16'h0000);
    chk("rst_ovf", score_ovf, 1'b0);
    chk("rst_dots", dots_left, 8'd150);
    chk("rst_lc", level_clear, 1'b0);
    chk("rst_ovr", tick_overrun, 1'b0);

    run_seq(85, 130, 6'd34, 1'b1, 1'b1, 1'b0);
    chk("rel_xpos", rel_xpos, 10'd85);
    chk("rel_ypos", rel_ypos, 9'd130);
    run_seq(375, 20, 6'd0, 1'b1, 1'b0, 1'b0);
    chk("ram_tile9", mem[9], 6'd0);

    w0 = we_cnt;
    run_seq(650, 20, 6'd34, 1'b1, 1'b1, 1'b0);
    run_seq(20, 500, 6'd34, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("skip_no_we", we_cnt - w0, 0);

    d0 = done_cnt;
    run_seq(85, 130, 6'd7, 1'b1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk("overrun_one_done", done_cnt - d0, 1);
    chk("tick_overrun", tick_overrun, EXP_OVR);

    @(negedge clk);
    xpos = 10'd300; ypos = 9'd300; blk_out = 6'd34; blk_we = 1'b1; blk_point = 1'b1; tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    chk("busy_div", busy, 1'b1);
    @(negedge clk); rst = 1'b1; w0 = we_cnt; d0 = done_cnt;
    @(negedge clk); rst = 1'b0;
    m_score = 0; m_dots = 150; m_ovf = 1'b0;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_score", score_bcd, 16'h0000);
    chk("mid_rst_dots", dots_left, 8'd150);
    chk("mid_rst_rel", rel_xpos, 10'd0);
    chk("mid_rst_ovr", tick_overrun, 1'b0);
    repeat (12) @(negedge clk);
    chk("mid_rst_no_we", we_cnt - w0, 0);
    chk("mid_rst_no_done", done_cnt - d0, 0);

    bulk(9999, 6'd0, 1'b1);
    chk("score_9999", score_bcd, 16'h9999);
    chk("ovf_pre", score_ovf, 1'b0);
    run_seq(85, 130, 6'd0, 1'b1, 1'b1, 1'b0);
    run_seq(85, 130, 6'd0, 1'b1, 1'b1, 1'b0);

    bulk(149, 6'd34, 1'b1);
    chk("dots_one", dots_left, 8'd1);
    run_seq(85, 130, 6'd34, 1'b1, 1'b1, 1'b0);
    run_seq(85, 130, 6'd34, 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
